// File: rtl/iq_buf_pkg.sv
// Shared types and defaults for the IQ symbol ping-pong buffer.
// Holds lane width, default geometry and the read-FSM state encoding.
package iq_buf_pkg;

    localparam int ANT   = 4;
    localparam int DEPTH = 1584;
    localparam int AW    = 11;

    typedef logic [31:0] iq_lane_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/iq_sdp_ram.sv
// Simple dual-port RAM, two banks of DEPTH words, 1-cycle registered read.
// Ports: clk, we/waddr/wdata (write), re/raddr/rdata (read); addr = {bank, re_idx}.
module iq_sdp_ram
    import iq_buf_pkg::*;
#(
    parameter int ANT   = iq_buf_pkg::ANT,
    parameter int DEPTH = iq_buf_pkg::DEPTH,
    parameter int AW    = iq_buf_pkg::AW
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW:0]          waddr,
    input  iq_lane_t [ANT-1:0]   wdata,
    input  logic                 re,
    input  logic [AW:0]          raddr,
    output iq_lane_t [ANT-1:0]   rdata
);

    iq_lane_t [ANT-1:0] mem [2][DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr[AW]][waddr[AW-1:0]] <= wdata;
        if (re)
            rdata <= mem[raddr[AW]][raddr[AW-1:0]];
    end

endmodule

// File: rtl/iq_sym_pingpong_buf.sv
// Two-bank symbol buffer between the IQ unpacker and a ready/valid consumer.
// Ports: i_clk, i_reset_n (async low); write side i_iq_addr/i_iq_data/i_iq_vld/
// i_iq_last; read side o_rd_data/o_rd_addr/o_rd_vld/o_rd_last with i_rd_ready;
// status o_bank_full, o_overflow, o_addr_err, o_drop_cnt.
// Optional macro IQ_BUF_DROP_CNT_EN enables the saturating drop counter.
module iq_sym_pingpong_buf
    import iq_buf_pkg::*;
#(
    parameter int ANT   = iq_buf_pkg::ANT,
    parameter int DEPTH = iq_buf_pkg::DEPTH,
    parameter int AW    = iq_buf_pkg::AW
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [AW-1:0]      i_iq_addr,
    input  iq_lane_t [ANT-1:0] i_iq_data,
    input  logic               i_iq_vld,
    input  logic               i_iq_last,
    input  logic               i_rd_ready,
    output iq_lane_t [ANT-1:0] o_rd_data,
    output logic [AW-1:0]      o_rd_addr,
    output logic               o_rd_vld,
    output logic               o_rd_last,
    output logic [1:0]         o_bank_full,
    output logic               o_overflow,
    output logic               o_addr_err,
    output logic [15:0]        o_drop_cnt
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    // Async assert, synchronous release.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            rst_sync <= '0;
        else
            rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    rd_state_t          state;
    logic               wr_sel, rd_sel;
    logic               wr_drop, in_sym;
    logic [1:0]         full, full_n;
    logic [AW-1:0]      rd_cnt;

    logic               p_vld, p_last;
    logic [AW-1:0]      p_addr;
    iq_lane_t [ANT-1:0] ram_dout;

    logic               sk_vld, sk_last;
    logic [AW-1:0]      sk_addr;
    iq_lane_t [ANT-1:0] sk_data;

    logic               pop, free_now, start, drop_now, drop_any;
    logic               addr_ok, wr_en, sym_done, issue;
    logic [1:0]         occ;

    assign pop      = o_rd_vld & i_rd_ready;
    assign free_now = pop & o_rd_last;

    // A bank whose last beat leaves this cycle counts as free.
    assign start    = i_iq_vld & ~in_sym;
    assign drop_now = start & full[wr_sel] & ~(free_now & (rd_sel == wr_sel));
    assign drop_any = wr_drop | drop_now;
    assign addr_ok  = 32'(i_iq_addr) < DEPTH;
    assign wr_en    = i_iq_vld & ~drop_any & addr_ok;
    assign sym_done = i_iq_last & ~drop_any & (in_sym | i_iq_vld);

    // Beats that will land in the output stage; keep room for one more.
    assign occ   = 2'(o_rd_vld) + 2'(sk_vld) + 2'(p_vld) - 2'(pop);
    assign issue = (state == ST_READ) && (occ <= 2'd1);

    always_comb begin
        full_n = full;
        if (free_now)
            full_n[rd_sel] = 1'b0;
        if (sym_done)
            full_n[wr_sel] = 1'b1;
    end

    assign o_bank_full = full;

    iq_sdp_ram #(
        .ANT   (ANT),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (i_clk),
        .we    (wr_en),
        .waddr ({wr_sel, i_iq_addr}),
        .wdata (i_iq_data),
        .re    (issue),
        .raddr ({rd_sel, rd_cnt}),
        .rdata (ram_dout)
    );

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel     <= 1'b0;
            wr_drop    <= 1'b0;
            in_sym     <= 1'b0;
            full       <= 2'b00;
            o_overflow <= 1'b0;
            o_addr_err <= 1'b0;
        end else begin
            full <= full_n;
            if (i_iq_vld && !addr_ok)
                o_addr_err <= 1'b1;
            if (drop_now)
                o_overflow <= 1'b1;
            if (i_iq_last) begin
                in_sym  <= 1'b0;
                wr_drop <= 1'b0;
            end else begin
                in_sym <= in_sym | i_iq_vld;
                if (drop_now)
                    wr_drop <= 1'b1;
            end
            if (sym_done)
                wr_sel <= ~wr_sel;
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            rd_sel <= 1'b0;
            rd_cnt <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (full[rd_sel]) begin
                        state  <= ST_READ;
                        rd_cnt <= '0;
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        if (rd_cnt == LAST_ADDR)
                            state <= ST_DRAIN;
                        else
                            rd_cnt <= rd_cnt + AW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (free_now) begin
                        state  <= ST_IDLE;
                        rd_sel <= ~rd_sel;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            p_vld  <= 1'b0;
            p_last <= 1'b0;
            p_addr <= '0;
        end else begin
            p_vld  <= issue;
            p_addr <= rd_cnt;
            p_last <= (rd_cnt == LAST_ADDR);
        end
    end

    // Output register is the FIFO head; the skid register catches the
    // in-flight RAM word when the head stalls.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rd_vld  <= 1'b0;
            o_rd_last <= 1'b0;
            o_rd_addr <= '0;
            o_rd_data <= '0;
            sk_vld    <= 1'b0;
            sk_last   <= 1'b0;
            sk_addr   <= '0;
            sk_data   <= '0;
        end else if (!o_rd_vld || pop) begin
            if (sk_vld) begin
                o_rd_vld  <= 1'b1;
                o_rd_data <= sk_data;
                o_rd_addr <= sk_addr;
                o_rd_last <= sk_last;
                sk_vld    <= p_vld;
                sk_data   <= ram_dout;
                sk_addr   <= p_addr;
                sk_last   <= p_last;
            end else if (p_vld) begin
                o_rd_vld  <= 1'b1;
                o_rd_data <= ram_dout;
                o_rd_addr <= p_addr;
                o_rd_last <= p_last;
            end else begin
                o_rd_vld  <= 1'b0;
                o_rd_last <= 1'b0;
            end
        end else if (p_vld) begin
            sk_vld  <= 1'b1;
            sk_data <= ram_dout;
            sk_addr <= p_addr;
            sk_last <= p_last;
        end
    end

`ifdef IQ_BUF_DROP_CNT_EN
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n)
            o_drop_cnt <= '0;
        else if (drop_now && o_drop_cnt != 16'hFFFF)
            o_drop_cnt <= o_drop_cnt + 16'd1;
    end
`else
    assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_iq_sym_pingpong_buf.sv
// Directed bench for iq_sym_pingpong_buf.
// Captures accepted beats and compares them with hand-built symbol patterns.
module tb_iq_sym_pingpong_buf;

    localparam int ANT   = 4;
    localparam int DEPTH = 1584;
    localparam int AW    = 11;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [AW-1:0]         iq_addr = '0;
    logic [ANT-1:0][31:0]  iq_data = '0;
    logic                  iq_vld = 1'b0;
    logic                  iq_last = 1'b0;
    logic                  rd_ready = 1'b0;
    logic [ANT-1:0][31:0]  rd_data;
    logic [AW-1:0]         rd_addr;
    logic                  rd_vld;
    logic                  rd_last;
    logic [1:0]            bank_full;
    logic                  overflow;
    logic                  addr_err;
    logic [15:0]           drop_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [127:0]  d;
        logic [AW-1:0] a;
        logic          l;
    } beat_t;

    beat_t        got[$];
    logic         stall_prev = 1'b0;
    logic [159:0] prev_v = '0;

    always #5 clk = ~clk;

    iq_sym_pingpong_buf dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_iq_addr   (iq_addr),
        .i_iq_data   (iq_data),
        .i_iq_vld    (iq_vld),
        .i_iq_last   (iq_last),
        .i_rd_ready  (rd_ready),
        .o_rd_data   (rd_data),
        .o_rd_addr   (rd_addr),
        .o_rd_vld    (rd_vld),
        .o_rd_last   (rd_last),
        .o_bank_full (bank_full),
        .o_overflow  (overflow),
        .o_addr_err  (addr_err),
        .o_drop_cnt  (drop_cnt)
    );

    task automatic chk(input string tag, input logic [159:0] got_v,
                       input logic [159:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    function automatic logic [127:0] pat(input int s, input int a);
        logic [127:0] v;
        for (int k = 0; k < ANT; k++)
            v[k*32 +: 32] = (s == 0) ? 32'(a) : {8'(s), 8'(k), 16'(a)};
        return v;
    endfunction

    always @(negedge clk) begin
        if (stall_prev)
            chk("stall_hold", {19'b0, rd_vld, rd_addr, rd_last, rd_data}, prev_v);
        stall_prev = rd_vld && !rd_ready && rst_n;
        prev_v = {19'b0, rd_vld, rd_addr, rd_last, rd_data};
        if (rd_vld && rd_ready)
            got.push_back('{d: rd_data, a: rd_addr, l: rd_last});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_sym(input int s, input int bad_at);
        for (int a = 0; a < DEPTH; a++) begin
            if (a == bad_at) begin
                iq_addr = 11'd1600;
                iq_data = '1;
                iq_vld  = 1'b1;
                iq_last = 1'b0;
                tick();
            end
            iq_addr = AW'(a);
            iq_data = pat(s, a);
            iq_vld  = 1'b1;
            iq_last = (a == DEPTH - 1);
            tick();
        end
        iq_vld  = 1'b0;
        iq_last = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        int c = 0;
        while (got.size() < n && c < budget) begin
            tick();
            c++;
        end
        chk(tag, 160'(got.size() >= n), 160'(1));
    endtask

    task automatic verify(input string tag, input int s, input int base);
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            beat_t b;
            b = (base + i < got.size()) ? got[base + i] : '0;
            if (b.a !== AW'(i) || b.d !== pat(s, i) || b.l !== (i == DEPTH - 1))
                bad++;
        end
        chk(tag, 160'(bad), 160'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        int n;
        int exp_drop;
`ifdef IQ_BUF_DROP_CNT_EN
        exp_drop = 1;
`else
        exp_drop = 0;
`endif
        // reset state
        repeat (3) tick();
        chk("rst_vld", 160'(rd_vld), 160'(0));
        chk("rst_addr", 160'(rd_addr), 160'(0));
        chk("rst_data", 160'(rd_data), 160'(0));
        chk("rst_full", 160'(bank_full), 160'(0));
        chk("rst_flags", 160'({overflow, addr_err, rd_last}), 160'(0));
        chk("rst_drop", 160'(drop_cnt), 160'(0));
        rst_n = 1'b1;
        repeat (3) tick();

        // single symbol, full rate, 3-cycle latency
        rd_ready = 1'b1;
        write_sym(0, -1);
        chk("s0_full", 160'(bank_full), 160'(2'b01));
        n = 0;
        while (!rd_vld && n < 10) begin
            tick();
            n++;
        end
        chk("s0_latency", 160'(n), 160'(3));
        wait_beats("s0_timeout", DEPTH, 4000);
        verify("s0_data", 0, 0);
        repeat (5) tick();
        chk("s0_full_clr", 160'(bank_full), 160'(2'b00));
        chk("s0_count", 160'(got.size()), 160'(DEPTH));

        // back-pressure, ready alternating
        got.delete();
        rd_ready = 1'b0;
        write_sym(2, -1);
        chk("s2_full", 160'(bank_full), 160'(2'b10));
        n = 0;
        while (got.size() < DEPTH && n < 8000) begin
            rd_ready = ~rd_ready;
            tick();
            n++;
        end
        rd_ready = 1'b1;
        repeat (10) tick();
        chk("bp_count", 160'(got.size()), 160'(DEPTH));
        verify("bp_data", 2, 0);
        chk("bp_full_clr", 160'(bank_full), 160'(2'b00));

        // overflow: three symbols, consumer stalled
        got.delete();
        rd_ready = 1'b0;
        write_sym(3, -1);
        write_sym(4, -1);
        chk("ovf_before", 160'(overflow), 160'(0));
        chk("ovf_full", 160'(bank_full), 160'(2'b11));
        write_sym(5, -1);
        chk("ovf_flag", 160'(overflow), 160'(1));
        chk("ovf_drop_cnt", 160'(drop_cnt), 160'(exp_drop));
        chk("ovf_full2", 160'(bank_full), 160'(2'b11));
        rd_ready = 1'b1;
        wait_beats("ovf_timeout", 2 * DEPTH, 8000);
        repeat (50) tick();
        chk("ovf_count", 160'(got.size()), 160'(2 * DEPTH));
        verify("ovf_s3", 3, 0);
        verify("ovf_s4", 4, DEPTH);
        chk("ovf_full_clr", 160'(bank_full), 160'(2'b00));

        do_reset();
        chk("rst2_ovf", 160'(overflow), 160'(0));
        chk("rst2_drop", 160'(drop_cnt), 160'(0));

        // same-cycle free of the target bank
        got.delete();
        rd_ready = 1'b0;
        write_sym(6, -1);
        write_sym(7, -1);
        rd_ready = 1'b1;
        n = 0;
        while (!(rd_vld && rd_last) && n < 4000) begin
            tick();
            n++;
        end
        chk("free_seen_last", 160'(rd_vld && rd_last), 160'(1));
        write_sym(8, -1);
        chk("free_no_ovf", 160'(overflow), 160'(0));
        wait_beats("free_timeout", 3 * DEPTH, 8000);
        verify("free_s6", 6, 0);
        verify("free_s7", 7, DEPTH);
        verify("free_s8", 8, 2 * DEPTH);

        // out-of-range write inside a symbol
        got.delete();
        chk("aerr_before", 160'(addr_err), 160'(0));
        write_sym(9, 100);
        chk("aerr_flag", 160'(addr_err), 160'(1));
        wait_beats("aerr_timeout", DEPTH, 4000);
        verify("aerr_data", 9, 0);
        chk("aerr_no_ovf", 160'(overflow), 160'(0));

        // async reset in the middle of a readout
        got.delete();
        write_sym(10, -1);
        n = 0;
        while (got.size() < 700 && n < 4000) begin
            tick();
            n++;
        end
        chk("mid_reached", 160'(got.size() >= 700), 160'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_vld", 160'(rd_vld), 160'(0));
        chk("mid_addr", 160'(rd_addr), 160'(0));
        chk("mid_data", 160'(rd_data), 160'(0));
        chk("mid_last_full", 160'({rd_last, bank_full}), 160'(0));
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        got.delete();
        write_sym(11, -1);
        wait_beats("post_timeout", DEPTH, 4000);
        verify("post_data", 11, 0);
        repeat (10) tick();
        chk("post_count", 160'(got.size()), 160'(DEPTH));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iq_sym_pingpong_buf.md
IQ_SYM_PINGPONG_BUF -- requirements
Module: iq_sym_pingpong_buf

Interface
REQ-001 SHALL have parameter ANT, default 4: number of antenna lanes.
REQ-002 SHALL have parameter DEPTH, default 1584: REs per symbol (132 PRB x 12).
REQ-003 SHALL have parameter AW, default 11: RE address width.
REQ-004 SHALL have port i_clk, input, 1: single clock for all logic.
REQ-005 SHALL have port i_reset_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port i_iq_addr, input, AW: write RE index from the unpacker.
REQ-007 SHALL have port i_iq_data, input, ANT x 32: unpacked IQ per antenna, {I[31:16], Q[15:0]}.
REQ-008 SHALL have port i_iq_vld, input, 1: write strobe for i_iq_addr and i_iq_data.
REQ-009 SHALL have port i_iq_last, input, 1: single-cycle end-of-symbol pulse, coincident with or after the final i_iq_vld.
REQ-010 SHALL have port i_rd_ready, input, 1: downstream ready.
REQ-011 SHALL have port o_rd_data, output, ANT x 32: read IQ.
REQ-012 SHALL have port o_rd_addr, output, AW: RE index of o_rd_data.
REQ-013 SHALL have port o_rd_vld, output, 1: read data valid.
REQ-014 SHALL have port o_rd_last, output, 1: asserted with the beat at o_rd_addr == DEPTH-1.
REQ-015 SHALL have port o_bank_full, output, 2: per-bank full flags.
REQ-016 SHALL have port o_overflow, output, 1: sticky; symbol dropped.
REQ-017 SHALL have port o_addr_err, output, 1: sticky; write with i_iq_addr >= DEPTH.
REQ-018 SHALL have port o_drop_cnt, output, 16: count of dropped symbols.

Function
REQ-019 SHALL write i_iq_data to bank wr_sel at i_iq_addr when i_iq_vld=1, wr_drop=0 and i_iq_addr < DEPTH.
REQ-020 SHALL, on i_iq_last while wr_drop=0, set full[wr_sel] and toggle wr_sel.
REQ-021 SHALL, when a write begins (first i_iq_vld after i_iq_last or reset) and full[wr_sel]=1, set wr_drop and o_overflow, and inhibit writes until the next i_iq_last.
REQ-022 SHALL, on that next i_iq_last, clear wr_drop without toggling wr_sel or setting any full flag.
REQ-023 SHALL, when a write would target a bank whose final beat is being accepted in the same cycle, accept the write without overflow (free takes precedence).
REQ-024 SHALL implement the read FSM IDLE -> READ -> DRAIN -> IDLE.
REQ-025 SHALL transition IDLE -> READ when full[rd_sel]=1.
REQ-026 SHALL, in READ, issue RAM reads from address 0 to DEPTH-1; DRAIN empties the output stage.
REQ-027 SHALL, on acceptance of the o_rd_last beat, clear full[rd_sel], toggle rd_sel, and return to IDLE.
REQ-028 SHALL have a RAM read latency of 1 cycle.
REQ-029 SHALL register outputs through a 2-entry skid stage so that full throughput (1 beat/cycle) is sustained while i_rd_ready=1.
REQ-030 SHALL hold o_rd_data, o_rd_addr, o_rd_vld and o_rd_last stable while o_rd_vld=1 and i_rd_ready=0; a beat transfers on o_rd_vld & i_rd_ready.
REQ-031 SHALL have a latency from i_iq_last (bank becomes full) to first o_rd_vld of 3 cycles when IDLE.
REQ-032 SHALL make o_addr_err sticky, discarding the offending write.
REQ-033 SHALL not affect bank state with i_iq_last received while no i_iq_vld has occurred since the previous i_iq_last (empty symbol), other than clearing wr_drop.

Reset
REQ-034 SHALL, on i_reset_n=0 (asynchronous), clear wr_sel, rd_sel, full, wr_drop, o_overflow, o_addr_err, o_drop_cnt, o_rd_vld and o_rd_last, set o_rd_addr=0, o_rd_data=0, and put the FSM in IDLE.
REQ-035 SHALL not reset RAM contents; a reset mid-symbol discards both banks.
REQ-036 SHALL synchronise reset deassertion to i_clk.

Configuration
REQ-037 SHALL, with IQ_BUF_DROP_CNT_EN defined, increment o_drop_cnt once per dropped symbol, saturating at 16'hFFFF.
REQ-038 SHALL, without IQ_BUF_DROP_CNT_EN, tie o_drop_cnt to 0 and leave o_overflow unchanged.

Structure
REQ-039 SHALL place ANT, DEPTH, AW, the IQ lane typedef (32-bit) and the read-FSM state enum in package iq_buf_pkg.
REQ-040 SHALL use one sub-module, iq_sdp_ram: simple dual-port, 2*DEPTH x (ANT*32), address {bank, addr}, 1-cycle registered read.

Verification
REQ-041 SHALL verify single symbol: 1584 writes of data=addr on all lanes, last pulse, ready=1 -> 1584 beats with o_rd_addr 0..1583 matching data, o_rd_last on 1583, o_bank_full back to 2'b00.
REQ-042 SHALL verify back-pressure: ready toggles 1/0 each cycle -> no beat lost or duplicated; data stable while stalled.
REQ-043 SHALL verify overflow: 3 symbols with ready=0 -> symbols 0 and 1 fill both banks, symbol 2 dropped, o_overflow=1, o_drop_cnt=1 (0 without macro); ready=1 then yields symbols 0 and 1 only.
REQ-044 SHALL verify same-cycle free: a new symbol's first write in the cycle the old bank's last beat is accepted -> no overflow.
REQ-045 SHALL verify address error: write at addr 1600 -> o_addr_err=1, RAM unchanged.
REQ-046 SHALL verify async reset mid-read at beat 700 -> outputs zero immediately, FSM IDLE, next symbol read from addr 0.
